// File: rtl/memory_dp_clr_if.sv
// Port bundle for memory_dp_clr: the clear handshake, port A read/write and port B read.
interface memory_dp_clr_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 8
);
    logic              clr;
    logic              busy;
    logic              we;
    logic [ADDR_W-1:0] addr_a;
    logic [DATA_W-1:0] d_i;
    logic [DATA_W-1:0] d_o_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] d_o_b;

    modport master (
        output clr, we, addr_a, d_i, addr_b,
        input  busy, d_o_a, d_o_b
    );

    modport slave (
        input  clr, we, addr_a, d_i, addr_b,
        output busy, d_o_a, d_o_b
    );
endinterface

// File: rtl/memory_dp_clr.sv
// Single-clock RAM: port A read/write with selectable read-during-write behaviour,
// port B read-only, and a clear engine that fills every word with CLR_VAL.
module memory_dp_clr #(
    parameter int unsigned        DATA_W    = 8,
    parameter int unsigned        ADDR_W    = 8,
    parameter int unsigned        READ_MODE = 0,
    parameter logic [DATA_W-1:0]  CLR_VAL   = '0
) (
    input  logic               clk,
    input  logic               rst,
    memory_dp_clr_if.slave     bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    if (READ_MODE > 2) begin : g_bad_mode
        $error("memory_dp_clr: READ_MODE must be 0, 1 or 2");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] doa_q, doa_d;
    logic [DATA_W-1:0] dob_q, dob_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_waddr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic [DATA_W-1:0] rd_a_c;
    logic [DATA_W-1:0] rd_b_c;

    assign rd_a_c = mem_q[bus.addr_a];
    assign rd_b_c = mem_q[bus.addr_b];

    // State and output registers; reset restarts the clear sweep from word 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            doa_q   <= '0;
            dob_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            doa_q   <= doa_d;
            dob_q   <= dob_d;
        end
    end

    // Storage array; the reset edge itself never writes a word.
    always_ff @(posedge clk) begin
        if (!rst && mem_we_c) begin
            mem_q[mem_waddr_c] <= mem_wdata_c;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        doa_d       = doa_q;
        dob_d       = dob_q;
        mem_we_c    = 1'b0;
        mem_waddr_c = bus.addr_a;
        mem_wdata_c = bus.d_i;

        case (state_q)
            CLEAR: begin
                mem_we_c    = 1'b1;
                mem_waddr_c = cnt_q;
                mem_wdata_c = CLR_VAL;
                cnt_d       = cnt_q + ADDR_W'(1);
                if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                if (bus.clr) begin
                    // A write presented together with clr is dropped.
                    state_d = CLEAR;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end else begin
                    mem_we_c = bus.we;
                    if (bus.we) begin
                        if (READ_MODE == 0) begin
                            doa_d = bus.d_i;
                        end else if (READ_MODE == 1) begin
                            doa_d = rd_a_c;
                        end
                    end else begin
                        doa_d = rd_a_c;
                    end
                    // Port B sees fresh data on a collision only in write-first mode.
                    if (bus.we && (bus.addr_a == bus.addr_b) && (READ_MODE == 0)) begin
                        dob_d = bus.d_i;
                    end else begin
                        dob_d = rd_b_c;
                    end
                end
            end
        endcase
    end

    assign bus.busy  = busy_q;
    assign bus.d_o_a = doa_q;
    assign bus.d_o_b = dob_q;
endmodule
